// File: rtl/addsub_bist_pkg.sv
// Shared types and constants for the add/sub self-test sequencer.
// Optional subtract sweep is enabled with the ADDSUB_BIST_SUB_EN macro.
package addsub_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    localparam int DEF_WIDTH         = 4;
    localparam int DEF_SETTLE_CYCLES = 3;
    localparam int DEF_ERRCNT_W      = 9;

endpackage

// File: rtl/addsub_bist_if.sv
// Bus between the self-test sequencer (master) and the add/sub datapath (slave).
interface addsub_bist_if #(
    parameter int WIDTH = 4
) ();
    logic [WIDTH-1:0] dut_a;
    logic [WIDTH-1:0] dut_b;
    logic             dut_addsub;
    logic [WIDTH-1:0] dut_s;
    logic             dut_overflow;

    modport master (
        output dut_a,
        output dut_b,
        output dut_addsub,
        input  dut_s,
        input  dut_overflow
    );

    modport slave (
        input  dut_a,
        input  dut_b,
        input  dut_addsub,
        output dut_s,
        output dut_overflow
    );
endinterface

// File: rtl/addsub_ref_model.sv
// Combinational golden model of a WIDTH-bit two's complement add/sub with overflow.
module addsub_ref_model
    import addsub_bist_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    output logic [WIDTH-1:0] exp_s,
    output logic             exp_ov
);
    logic [WIDTH:0] a_x;
    logic [WIDTH:0] b_x;
    logic [WIDTH:0] r;

    assign a_x = {a[WIDTH-1], a};
    assign b_x = {b[WIDTH-1], b};
    assign r   = (mode == MODE_SUB) ? (a_x - b_x) : (a_x + b_x);

    assign exp_s  = r[WIDTH-1:0];
    // The extra result bit disagrees with the sum's sign bit exactly on overflow.
    assign exp_ov = r[WIDTH] ^ r[WIDTH-1];
endmodule

// File: rtl/addsub_bist.sv
// Exhaustive self-test sequencer for the signed add/sub datapath.
// Define ADDSUB_BIST_SUB_EN to sweep subtraction after addition.
module addsub_bist
    import addsub_bist_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int ERRCNT_W      = DEF_ERRCNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ERRCNT_W-1:0] err_count,
    output logic                first_err_valid,
    output logic [WIDTH-1:0]    first_err_a,
    output logic [WIDTH-1:0]    first_err_b,
    output logic                first_err_mode,
    addsub_bist_if.master       dp
);
    localparam logic [WIDTH-1:0]    OP_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0]    OP_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [ERRCNT_W-1:0] ERR_MAX = {ERRCNT_W{1'b1}};
    localparam logic [3:0]          SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t              state_q;
    logic [WIDTH-1:0]    a_q, b_q;
    logic                mode_q;
    logic [3:0]          settle_q;
    logic                busy_q, done_q, pass_q;
    logic [ERRCNT_W-1:0] err_q, err_d;
    logic                fev_q;
    logic [WIDTH-1:0]    fea_q, feb_q;
    logic                fem_q;

    logic [WIDTH-1:0]    exp_s;
    logic                exp_ov;
    logic                mismatch;
    logic                a_last, b_last, last_vec;

    addsub_ref_model #(.WIDTH(WIDTH)) u_model (
        .a      (a_q),
        .b      (b_q),
        .mode   (mode_q),
        .exp_s  (exp_s),
        .exp_ov (exp_ov)
    );

    assign mismatch = (dp.dut_s != exp_s) || (dp.dut_overflow != exp_ov);
    assign a_last   = (a_q == OP_MAX);
    assign b_last   = (b_q == OP_MAX);

    always_comb begin
        err_d = err_q;
        if (mismatch && (err_q != ERR_MAX)) begin
            err_d = err_q + 1'b1;
        end
    end

`ifdef ADDSUB_BIST_SUB_EN
    assign last_vec = a_last && b_last && (mode_q == MODE_SUB);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= MODE_ADD;
        end else if ((state_q == ST_IDLE) && start) begin
            mode_q <= MODE_ADD;
        end else if ((state_q == ST_CHECK) && a_last && b_last) begin
            mode_q <= ~mode_q;
        end
    end
`else
    assign last_vec = a_last && b_last;
    assign mode_q   = MODE_ADD;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            settle_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= '0;
            fev_q    <= 1'b0;
            fea_q    <= '0;
            feb_q    <= '0;
            fem_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        err_q   <= '0;
                        pass_q  <= 1'b0;
                        fev_q   <= 1'b0;
                        fea_q   <= '0;
                        feb_q   <= '0;
                        fem_q   <= 1'b0;
                        a_q     <= OP_MIN;
                        b_q     <= OP_MIN;
                        busy_q  <= 1'b1;
                        state_q <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    settle_q <= SETTLE_LOAD;
                    state_q  <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_q == 4'd0) begin
                        state_q <= ST_CHECK;
                    end else begin
                        settle_q <= settle_q - 1'b1;
                    end
                end
                ST_CHECK: begin
                    err_q <= err_d;
                    if (mismatch && !fev_q) begin
                        fev_q <= 1'b1;
                        fea_q <= a_q;
                        feb_q <= b_q;
                        fem_q <= mode_q;
                    end
                    // b is the inner loop; a steps only when b wraps.
                    b_q <= b_last ? OP_MIN : b_q + 1'b1;
                    if (b_last) begin
                        a_q <= a_last ? OP_MIN : a_q + 1'b1;
                    end
                    if (last_vec) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_d == '0);
                        state_q <= ST_DONE;
                    end else begin
                        state_q <= ST_DRIVE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign dp.dut_a      = a_q;
    assign dp.dut_b      = b_q;
    assign dp.dut_addsub = mode_q;

    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign first_err_valid = fev_q;
    assign first_err_a     = fea_q;
    assign first_err_b     = feb_q;
    assign first_err_mode  = fem_q;
endmodule

// File: tb/tb_addsub_bist.sv
// Directed bench: behavioural add/sub datapath with selectable faults beside addsub_bist.
module tb_addsub_bist;
`ifdef ADDSUB_BIST_SUB_EN
    localparam int N_VEC = 512;
`else
    localparam int N_VEC = 256;
`endif
    localparam int DONE_CYC  = N_VEC * 5 + 1;
    localparam int BUSY_CYC  = N_VEC * 5;
    localparam int OVINV_ERR = (N_VEC > 511) ? 511 : N_VEC;
    localparam int S0_ERR    = N_VEC / 2;
    localparam int MAX_WAIT  = 3000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       busy, done, pass;
    logic [8:0] err_count;
    logic       first_err_valid;
    logic [3:0] first_err_a, first_err_b;
    logic       first_err_mode;

    int n_assert = 0;
    int n_fail   = 0;
    int fault_sel = 0;   // 0 none, 1 S[0] stuck-0, 2 OV forced 0 at 7+1, 3 OV inverted

    addsub_bist_if #(.WIDTH(4)) dp_if ();

    addsub_bist dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_count       (err_count),
        .first_err_valid (first_err_valid),
        .first_err_a     (first_err_a),
        .first_err_b     (first_err_b),
        .first_err_mode  (first_err_mode),
        .dp              (dp_if.master)
    );

    always #5 clk = ~clk;

    int         av, bv, r_int;
    logic [3:0] model_s;
    logic       model_ov;

    assign av = int'($signed(dp_if.dut_a));
    assign bv = int'($signed(dp_if.dut_b));

    always_comb begin
        r_int    = dp_if.dut_addsub ? (av - bv) : (av + bv);
        model_s  = r_int[3:0];
        model_ov = (r_int > 7) || (r_int < -8);
        if (fault_sel == 1) model_s[0] = 1'b0;
        if (fault_sel == 2 && av == 7 && bv == 1) model_ov = 1'b0;
        if (fault_sel == 3) model_ov = ~model_ov;
    end

    assign dp_if.dut_s        = model_s;
    assign dp_if.dut_overflow = model_ov;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered in cycle 1 of a sweep; returns in the DONE cycle (0 on timeout).
    task automatic wait_done(output int done_cyc, output int busy_cnt);
        int c;
        done_cyc = 0;
        busy_cnt = 0;
        c = 1;
        while (done_cyc == 0 && c <= MAX_WAIT) begin
            if (busy) busy_cnt++;
            if (done) done_cyc = c;
            if (done_cyc == 0) begin
                step();
                c++;
            end
        end
    endtask

    task automatic run_sweep(input bit hold, output int done_cyc, output int busy_cnt);
        start = 1'b1;
        step();
        if (!hold) start = 1'b0;
        wait_done(done_cyc, busy_cnt);
    endtask

    initial begin
        int dc, bc, dn;

        // Reset state
        step();
        step();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", err_count, 0);
        check("rst_dut_a", dp_if.dut_a, 0);
        check("rst_dut_b", dp_if.dut_b, 0);
        check("rst_addsub", dp_if.dut_addsub, 0);
        check("rst_fev", first_err_valid, 0);
        rst = 1'b0;
        step();
        $display("txn reset: busy=%0d done=%0d err=%0d", busy, done, err_count);

        // Clean sweep
        fault_sel = 0;
        run_sweep(1'b0, dc, bc);
        check("clean_done_cyc", dc, DONE_CYC);
        check("clean_busy_cyc", bc, BUSY_CYC);
        check("clean_pass", pass, 1);
        check("clean_err", err_count, 0);
        check("clean_fev", first_err_valid, 0);
        step();
        check("clean_done_pulse", done, 0);
        check("clean_pass_held", pass, 1);
        $display("txn clean sweep: done_cyc=%0d busy=%0d err=%0d pass=%0d", dc, bc, err_count, pass);

        // S[0] stuck-at-0
        fault_sel = 1;
        run_sweep(1'b0, dc, bc);
        check("s0_done_cyc", dc, DONE_CYC);
        check("s0_err", err_count, S0_ERR);
        check("s0_pass", pass, 0);
        check("s0_fev", first_err_valid, 1);
        check("s0_fea", first_err_a, 4'b1000);
        check("s0_feb", first_err_b, 4'b1001);
        check("s0_fem", first_err_mode, 0);
        step();
        $display("txn s0 stuck: err=%0d first=%b/%b pass=%0d", err_count, first_err_a, first_err_b, pass);

        // Single-vector overflow fault
        fault_sel = 2;
        run_sweep(1'b0, dc, bc);
        check("ov1_err", err_count, 1);
        check("ov1_fea", first_err_a, 4'b0111);
        check("ov1_feb", first_err_b, 4'b0001);
        check("ov1_fem", first_err_mode, 0);
        check("ov1_pass", pass, 0);
        step();
        $display("txn ov single: err=%0d first=%b/%b", err_count, first_err_a, first_err_b);

        // Overflow inverted: every vector fails
        fault_sel = 3;
        run_sweep(1'b0, dc, bc);
        check("ovinv_done_cyc", dc, DONE_CYC);
        check("ovinv_err", err_count, OVINV_ERR);
        check("ovinv_fea", first_err_a, 4'b1000);
        check("ovinv_feb", first_err_b, 4'b1000);
        check("ovinv_pass", pass, 0);
        step();
        $display("txn ov inverted: err=%0d pass=%0d", err_count, pass);

        // Reset mid-sweep, with errors already accumulating
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (599) step();
        check("mid_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        check("mid_err_async", err_count, 0);
        step();
        check("mid_busy", busy, 0);
        check("mid_done", done, 0);
        check("mid_err", err_count, 0);
        check("mid_fev", first_err_valid, 0);
        check("mid_dut_a", dp_if.dut_a, 0);
        check("mid_dut_b", dp_if.dut_b, 0);
        rst = 1'b0;
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done || busy) dn++;
        end
        check("mid_no_restart", dn, 0);
        fault_sel = 0;
        run_sweep(1'b0, dc, bc);
        check("mid_fresh_done_cyc", dc, DONE_CYC);
        check("mid_fresh_pass", pass, 1);
        step();
        $display("txn reset mid-sweep: fresh done_cyc=%0d pass=%0d", dc, pass);

        // start held high throughout
        run_sweep(1'b1, dc, bc);
        check("hold_done_cyc", dc, DONE_CYC);
        check("hold_pass", pass, 1);
        step();
        check("hold_idle_busy", busy, 0);
        check("hold_idle_pass", pass, 1);
        step();
        check("hold_relaunch_busy", busy, 1);
        check("hold_relaunch_pass", pass, 0);
        wait_done(dc, bc);
        check("hold_second_done_cyc", dc, DONE_CYC);
        start = 1'b0;
        step();
        step();
        check("hold_stop_busy", busy, 0);
        $display("txn start held: second done_cyc=%0d pass=%0d", dc, pass);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
